// File: rtl/prbs_lane_gen_chk_if.sv
// Signal bundle for prbs_lane_gen_chk: generator controls and outputs,
// per-lane receive words and checker status.
interface prbs_lane_gen_chk_if #(
  parameter int NUM_LANES = 1,
  parameter int DATA_W    = 32,
  parameter int ERR_CNT_W = 32
);
  logic [1:0]                     mode;
  logic                           gen_en;
  logic                           inj_err;
  logic [NUM_LANES*DATA_W-1:0]    tx_data;
  logic                           tx_valid;
  logic [NUM_LANES*DATA_W-1:0]    rx_data;
  logic [NUM_LANES-1:0]           rx_valid;
  logic                           chk_clr;
  logic [NUM_LANES-1:0]           lane_locked;
  logic [NUM_LANES*ERR_CNT_W-1:0] err_cnt;

  // Transceiver/register side: drives controls and received words.
  modport master (
    output mode, gen_en, inj_err, rx_data, rx_valid, chk_clr,
    input  tx_data, tx_valid, lane_locked, err_cnt
  );

  // Pattern generator/checker side.
  modport slave (
    input  mode, gen_en, inj_err, rx_data, rx_valid, chk_clr,
    output tx_data, tx_valid, lane_locked, err_cnt
  );
endinterface

// File: rtl/prbs_lane_gen_chk.sv
// Multi-lane PRBS7/15/23/31 generator with per-lane self-synchronising
// checkers and saturating bit-error counters. Bit 0 of a word is first in time.
// Optional error injection is built only when PRBS_ERR_INJECT_EN is defined.
module prbs_lane_gen_chk #(
  parameter int NUM_LANES = 1,
  parameter int DATA_W    = 32,
  parameter int LOCK_CNT  = 16,
  parameter int LOSS_CNT  = 8,
  parameter int ERR_CNT_W = 32
) (
  input logic                clk,
  input logic                rst,
  prbs_lane_gen_chk_if.slave bus
);
  // The shift history always holds the last 31 sequence bits; shorter
  // polynomials simply tap lower entries.
  localparam int SR_W  = 31;
  localparam int PC_W  = $clog2(DATA_W + 1);
  localparam int SUM_W = ERR_CNT_W + PC_W;
  localparam logic [7:0] LOCK_MAX = 8'(LOCK_CNT);
  localparam logic [7:0] LOSS_MAX = 8'(LOSS_CNT);

  typedef enum logic [1:0] {UNLOCKED = 2'd0, LOCKING = 2'd1, LOCKED = 2'd2} chk_state_t;

  // history[k] is the sequence bit emitted k+1 steps ago.
  function automatic logic [DATA_W-1:0] prbs_word(input logic [SR_W-1:0] seed,
                                                  input logic [1:0] m);
    logic [SR_W-1:0]   sr;
    logic [DATA_W-1:0] w;
    logic              b;
    sr = seed;
    w  = '0;
    for (int k = 0; k < DATA_W; k++) begin
      case (m)
        2'd0:    b = sr[6]  ^ sr[5];
        2'd1:    b = sr[14] ^ sr[13];
        2'd2:    b = sr[22] ^ sr[17];
        default: b = sr[30] ^ sr[27];
      endcase
      w[k] = b;
      sr   = {sr[SR_W-2:0], b};
    end
    return w;
  endfunction

  // The last bits of a word are the LFSR state that continues the sequence.
  function automatic logic [SR_W-1:0] word_to_state(input logic [DATA_W-1:0] w);
    logic [SR_W-1:0] s;
    for (int k = 0; k < SR_W; k++) s[k] = w[DATA_W-1-k];
    return s;
  endfunction

  function automatic logic [PC_W-1:0] popcount(input logic [DATA_W-1:0] w);
    logic [PC_W-1:0] c;
    c = '0;
    for (int k = 0; k < DATA_W; k++) c = c + PC_W'(w[k]);
    return c;
  endfunction

  function automatic logic [ERR_CNT_W-1:0] sat_add(input logic [ERR_CNT_W-1:0] a,
                                                   input logic [PC_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = SUM_W'(a) + SUM_W'(b);
    if (|s[SUM_W-1:ERR_CNT_W]) return '1;
    else return s[ERR_CNT_W-1:0];
  endfunction

  logic [1:0]                  mode_q;
  logic                        mode_chg;
  logic [SR_W-1:0]             gen_sr;
  logic [SR_W-1:0]             gen_seed;
  logic [DATA_W-1:0]           gen_word;
  logic [DATA_W-1:0]           tx_word;
  logic [NUM_LANES*DATA_W-1:0] tx_data_q;
  logic                        tx_valid_q;
  logic                        inj_bit;

  // A mode change reseeds in the same cycle, so a word generated then is
  // already the first word of the new pattern.
  assign mode_chg = (bus.mode != mode_q);
  assign gen_seed = mode_chg ? '1 : gen_sr;
  assign gen_word = prbs_word(gen_seed, bus.mode);

`ifdef PRBS_ERR_INJECT_EN
  logic inj_pend;

  // Hold an injection request until the next generated word; repeats merge.
  always_ff @(posedge clk) begin
    if (rst)              inj_pend <= 1'b0;
    else if (bus.gen_en)  inj_pend <= 1'b0;
    else if (bus.inj_err) inj_pend <= 1'b1;
  end

  assign inj_bit = bus.gen_en & (inj_pend | bus.inj_err);
`else
  logic unused_inj;
  assign unused_inj = bus.inj_err;
  assign inj_bit    = 1'b0;
`endif

  // Injection corrupts only the transmitted word, never the LFSR state.
  assign tx_word = gen_word ^ {{(DATA_W-1){1'b0}}, inj_bit};

  // Generator state and registered transmit word.
  always_ff @(posedge clk) begin
    mode_q <= bus.mode;
    if (rst) begin
      gen_sr     <= '1;
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
    end else begin
      tx_valid_q <= bus.gen_en;
      if (bus.gen_en) begin
        gen_sr    <= word_to_state(gen_word);
        tx_data_q <= {NUM_LANES{tx_word}};
      end else if (mode_chg) begin
        gen_sr <= '1;
      end
    end
  end

  assign bus.tx_data  = tx_data_q;
  assign bus.tx_valid = tx_valid_q;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
    chk_state_t        state_q, state_nx;
    logic [7:0]        cnt_q, cnt_nx;
    logic [SR_W-1:0]   sr_q, sr_nx;
    logic [DATA_W-1:0] rx_w, pred, diff;
    logic [PC_W-1:0]   pc_nx, pc_p1;
    logic [ERR_CNT_W-1:0] err_q;

    assign rx_w = bus.rx_data[i*DATA_W +: DATA_W];
    assign pred = prbs_word(sr_q, bus.mode);
    assign diff = rx_w ^ pred;

    // Lock FSM: seed, count matches to lock, count consecutive misses to drop.
    always_comb begin
      state_nx = state_q;
      cnt_nx   = cnt_q;
      sr_nx    = sr_q;
      pc_nx    = '0;
      if (mode_chg) begin
        state_nx = UNLOCKED;
        cnt_nx   = '0;
      end else if (bus.rx_valid[i]) begin
        case (state_q)
          UNLOCKED: begin
            if (rx_w != '0) begin
              sr_nx    = word_to_state(rx_w);
              state_nx = LOCKING;
              cnt_nx   = '0;
            end
          end
          LOCKING: begin
            sr_nx = word_to_state(pred);
            if (diff == '0) begin
              if (cnt_q + 8'd1 == LOCK_MAX) begin
                state_nx = LOCKED;
                cnt_nx   = '0;
              end else begin
                cnt_nx = cnt_q + 8'd1;
              end
            end else begin
              state_nx = UNLOCKED;
              cnt_nx   = '0;
            end
          end
          LOCKED: begin
            sr_nx = word_to_state(pred);
            if (diff != '0) begin
              pc_nx = popcount(diff);
              if (cnt_q + 8'd1 == LOSS_MAX) begin
                state_nx = UNLOCKED;
                cnt_nx   = '0;
              end else begin
                cnt_nx = cnt_q + 8'd1;
              end
            end else begin
              cnt_nx = '0;
            end
          end
          default: begin
            state_nx = UNLOCKED;
            cnt_nx   = '0;
          end
        endcase
      end
    end

    // Checker control registers.
    always_ff @(posedge clk) begin
      if (rst) begin
        state_q <= UNLOCKED;
        cnt_q   <= '0;
      end else begin
        state_q <= state_nx;
        cnt_q   <= cnt_nx;
      end
    end

    // Lane LFSR history; only meaningful once seeded, so it carries no reset.
    always_ff @(posedge clk) begin
      sr_q <= sr_nx;
    end

    // Stage p1: registered popcount, then saturating add; clear drops both.
    always_ff @(posedge clk) begin
      if (rst || bus.chk_clr) begin
        pc_p1 <= '0;
        err_q <= '0;
      end else begin
        pc_p1 <= pc_nx;
        err_q <= sat_add(err_q, pc_p1);
      end
    end

    assign bus.lane_locked[i]                     = (state_q == LOCKED);
    assign bus.err_cnt[i*ERR_CNT_W +: ERR_CNT_W] = err_q;
  end
endmodule

// File: tb/tb_prbs_lane_gen_chk.sv
// Bench for prbs_lane_gen_chk: 4 lanes in loopback with a bit-sequence model
// of the PRBS recurrences and lock rules, plus directed literal checks.
module tb_prbs_lane_gen_chk;
  localparam int NL = 4;
  localparam int DW = 32;
  localparam int EW = 4;
  localparam int LOCK_N = 16;
  localparam int LOSS_N = 8;
  localparam int ERR_MAX = (1 << EW) - 1;

  typedef bit bitq_t[$];

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  prbs_lane_gen_chk_if #(.NUM_LANES(NL), .DATA_W(DW), .ERR_CNT_W(EW)) bus ();

  prbs_lane_gen_chk #(
    .NUM_LANES(NL), .DATA_W(DW), .LOCK_CNT(LOCK_N), .LOSS_CNT(LOSS_N), .ERR_CNT_W(EW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [NL*DW-1:0] flip, rmask, rword;
  assign bus.rx_data  = ((bus.tx_data & ~rmask) | (rword & rmask)) ^ flip;
  assign bus.rx_valid = {NL{bus.tx_valid}};

  int n_cmp = 0;
  int n_fail = 0;
  bit cmp_on = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- model: PRBS as a bit sequence ----------------
  function automatic int tap_n(input logic [1:0] m);
    case (m)
      2'd0: return 7;
      2'd1: return 15;
      2'd2: return 23;
      default: return 31;
    endcase
  endfunction

  function automatic int tap_m(input logic [1:0] m);
    case (m)
      2'd0: return 6;
      2'd1: return 14;
      2'd2: return 18;
      default: return 28;
    endcase
  endfunction

  // s[n] = s[n-N] ^ s[n-M], continuing the given history.
  function automatic logic [31:0] next_word(input bitq_t h, input logic [1:0] m);
    logic [31:0] w;
    int n, t;
    n = tap_n(m);
    t = tap_m(m);
    for (int k = 0; k < 32; k++) begin
      w[k] = h[h.size() - n] ^ h[h.size() - t];
      h.push_back(w[k]);
    end
    return w;
  endfunction

  function automatic bitq_t append_word(input bitq_t h, input logic [31:0] w);
    for (int k = 0; k < 32; k++) h.push_back(w[k]);
    while (h.size() > 31) void'(h.pop_front());
    return h;
  endfunction

  function automatic bitq_t all_ones();
    bitq_t h;
    repeat (31) h.push_back(1'b1);
    return h;
  endfunction

  bitq_t gh;
  bitq_t lh [NL];
  bitq_t emptyq;
  int m_state [NL];   // 0 unlocked, 1 locking, 2 locked
  int m_cnt [NL];
  int m_err [NL];
  int m_pend [NL];
  logic [1:0] m_mode_q;
  bit m_ipend;
  logic [NL*DW-1:0] exp_tx;
  logic exp_txv;

  always @(posedge clk) begin
    logic [31:0] w, rw, pw;
    bit chg, inj_now;
    int newpc;
    if (rst) begin
      gh = all_ones();
      m_mode_q = bus.mode;
      m_ipend = 0;
      exp_tx = '0;
      exp_txv = 0;
      for (int l = 0; l < NL; l++) begin
        m_state[l] = 0; m_cnt[l] = 0; m_err[l] = 0; m_pend[l] = 0;
      end
    end else begin
      chg = (bus.mode != m_mode_q);
      m_mode_q = bus.mode;
      if (chg) gh = all_ones();
      inj_now = 0;
`ifdef PRBS_ERR_INJECT_EN
      inj_now = bus.gen_en && (m_ipend || bus.inj_err);
      m_ipend = bus.gen_en ? 1'b0 : (m_ipend || bus.inj_err);
`endif
      if (bus.gen_en) begin
        w = next_word(gh, bus.mode);
        gh = append_word(gh, w);
        exp_tx = {NL{w ^ {31'b0, inj_now}}};
        exp_txv = 1;
      end else begin
        exp_txv = 0;
      end
      for (int l = 0; l < NL; l++) begin
        if (bus.chk_clr) m_err[l] = 0;
        else m_err[l] = (m_err[l] + m_pend[l] > ERR_MAX) ? ERR_MAX : m_err[l] + m_pend[l];
        newpc = 0;
        if (chg) begin
          m_state[l] = 0; m_cnt[l] = 0;
        end else if (bus.rx_valid[l]) begin
          rw = bus.rx_data[l*DW +: DW];
          if (m_state[l] == 0) begin
            if (rw != 0) begin
              lh[l] = append_word(emptyq, rw);
              m_state[l] = 1; m_cnt[l] = 0;
            end
          end else begin
            pw = next_word(lh[l], bus.mode);
            lh[l] = append_word(lh[l], pw);
            if (m_state[l] == 1) begin
              if (rw == pw) begin
                m_cnt[l]++;
                if (m_cnt[l] == LOCK_N) begin m_state[l] = 2; m_cnt[l] = 0; end
              end else begin
                m_state[l] = 0; m_cnt[l] = 0;
              end
            end else if (rw != pw) begin
              newpc = $countones(rw ^ pw);
              m_cnt[l]++;
              if (m_cnt[l] == LOSS_N) begin m_state[l] = 0; m_cnt[l] = 0; end
            end else begin
              m_cnt[l] = 0;
            end
          end
        end
        m_pend[l] = bus.chk_clr ? 0 : newpc;
      end
    end
  end

  // Compare DUT outputs against the model every cycle.
  always @(negedge clk) begin
    logic [NL-1:0] exp_lock;
    logic [NL*EW-1:0] exp_err;
    if (cmp_on) begin
      for (int l = 0; l < NL; l++) begin
        exp_lock[l] = (m_state[l] == 2);
        exp_err[l*EW +: EW] = EW'(m_err[l]);
      end
      check("model tx_valid", 128'(bus.tx_valid), 128'(exp_txv));
      check("model tx_data", 128'(bus.tx_data), 128'(exp_tx));
      check("model lane_locked", 128'(bus.lane_locked), 128'(exp_lock));
      check("model err_cnt", 128'(bus.err_cnt), 128'(exp_err));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  function automatic logic [127:0] lane_err(input int l);
    return 128'(bus.err_cnt[l*EW +: EW]);
  endfunction

  int exp_inj;

  initial begin
    rst = 1'b1;
    bus.mode = 2'd3; bus.gen_en = 1'b0; bus.inj_err = 1'b0; bus.chk_clr = 1'b0;
    flip = '0; rmask = '0; rword = '0;
    repeat (3) @(negedge clk);
    check("reset tx_data", 128'(bus.tx_data), 128'd0);
    check("reset tx_valid", 128'(bus.tx_valid), 128'd0);
    check("reset lane_locked", 128'(bus.lane_locked), 128'd0);
    check("reset err_cnt", 128'(bus.err_cnt), 128'd0);
    cmp_on = 1;

    // PRBS31 loopback lock
    rst = 1'b0; bus.gen_en = 1'b1;
    @(negedge clk);
    check("prbs31 first word", 128'(bus.tx_data), {4{32'h7000_0000}});
    check("first tx_valid", 128'(bus.tx_valid), 128'd1);
    repeat (16) @(negedge clk);
    check("not locked after 16 words", 128'(bus.lane_locked), 128'h0);
    @(negedge clk);
    check("locked after 17 words", 128'(bus.lane_locked), 128'hF);
    repeat (10000) @(negedge clk);
    check("no errors in 10000 words", 128'(bus.err_cnt), 128'd0);

    // 3-bit error on lane 2
    flip = 128'h0001_0201 << 64;
    @(negedge clk);
    flip = '0;
    check("lane2 err after 1 edge", lane_err(2), 128'd0);
    @(negedge clk);
    check("lane2 err after 2 edges", lane_err(2), 128'd3);
    check("lane0 err untouched", lane_err(0), 128'd0);
    check("lane3 err untouched", lane_err(3), 128'd0);
    check("all locked after flip", 128'(bus.lane_locked), 128'hF);

    // error injection, last request while gen_en=0
    bus.chk_clr = 1'b1;
    @(negedge clk);
    bus.chk_clr = 1'b0;
    check("clr zeroes counters", 128'(bus.err_cnt), 128'd0);
    for (int p = 0; p < 5; p++) begin
      if (p == 4) bus.gen_en = 1'b0;
      bus.inj_err = 1'b1;
      @(negedge clk);
      bus.inj_err = 1'b0;
      repeat (2) @(negedge clk);
      bus.gen_en = 1'b1;
      repeat (97) @(negedge clk);
    end
`ifdef PRBS_ERR_INJECT_EN
    exp_inj = 5;
`else
    exp_inj = 0;
`endif
    for (int l = 0; l < NL; l++) check("inject count", lane_err(l), 128'(exp_inj));
    check("locked after inject", 128'(bus.lane_locked), 128'hF);

    // 8 random words on lane 1 drop lock, 17 good words relock
    rmask = 128'hFFFF_FFFF << 32;
    rword = 128'($urandom) << 32;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 7) check("lane1 locked after 7 bad", 128'(bus.lane_locked[1]), 128'd1);
      rword = 128'($urandom) << 32;
    end
    check("lane1 unlocked after 8 bad", 128'(bus.lane_locked[1]), 128'd0);
    rmask = '0;
    repeat (16) @(negedge clk);
    check("lane1 not relocked at 16", 128'(bus.lane_locked[1]), 128'd0);
    @(negedge clk);
    check("lane1 relocked at 17", 128'(bus.lane_locked[1]), 128'd1);

    // saturation on lane 0, then clear racing an add
    bus.chk_clr = 1'b1;
    @(negedge clk);
    bus.chk_clr = 1'b0;
    for (int k = 0; k < 20; k++) begin
      flip = 128'(1) << k;
      @(negedge clk);
      flip = '0;
      @(negedge clk);
    end
    check("lane0 saturated", lane_err(0), 128'd15);
    flip = 128'h1;
    @(negedge clk);
    flip = '0;
    bus.chk_clr = 1'b1;
    @(negedge clk);
    bus.chk_clr = 1'b0;
    check("clr beats add", lane_err(0), 128'd0);
    @(negedge clk);
    check("in-flight add discarded", lane_err(0), 128'd0);

    // switch to PRBS7 while locked
    bus.mode = 2'd0;
    @(negedge clk);
    check("mode change unlocks", 128'(bus.lane_locked), 128'h0);
    check("prbs7 first word", 128'(bus.tx_data), {4{32'h4F14_3040}});
    repeat (16) @(negedge clk);
    check("prbs7 not locked at 16", 128'(bus.lane_locked), 128'h0);
    @(negedge clk);
    check("prbs7 locked at 17", 128'(bus.lane_locked), 128'hF);

    // reset in mid-lock with a nonzero counter
    flip = 128'h1 << 96;
    @(negedge clk);
    flip = '0;
    @(negedge clk);
    check("lane3 err before reset", lane_err(3), 128'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid reset tx_data", 128'(bus.tx_data), 128'd0);
    check("mid reset tx_valid", 128'(bus.tx_valid), 128'd0);
    check("mid reset lane_locked", 128'(bus.lane_locked), 128'h0);
    check("mid reset err_cnt", 128'(bus.err_cnt), 128'd0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    cmp_on = 0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/prbs_lane_gen_chk.md
# prbs_lane_gen_chk

Parametrised multi-lane PRBS generator and self-synchronising checker for GTH serial-link bring-up and BER measurement. It supersedes the single-lane, fixed-LFSR SFP test-pattern driver. It sits between the transceiver user-data ports (TX/RX parallel words) and the AXI register block, which reads the lock and error-count outputs. The generator and checker are independent per lane, so loopback, far-end and lane-to-lane tests all use one instance.

## Interface
Parameters:
- NUM_LANES, 1, number of independent lanes.
- DATA_W, 32, parallel word width per lane; must be >= 32.
- LOCK_CNT, 16, consecutive matching words required to declare lock; range 1..255.
- LOSS_CNT, 8, consecutive mismatching words that drop lock; range 1..255.
- ERR_CNT_W, 32, width of each per-lane bit-error counter.

Ports:
- clk  in  1  single clock for all logic (transceiver user clock).
- rst  in  1  synchronous, active-high reset.
- mode  in  2  pattern: 0 PRBS7 (x^7+x^6+1), 1 PRBS15 (x^15+x^14+1), 2 PRBS23 (x^23+x^18+1), 3 PRBS31 (x^31+x^28+1).
- gen_en  in  1  advance the generator one word per cycle.
- inj_err  in  1  single-cycle error-injection request.
- tx_data  out  NUM_LANES*DATA_W  generated words; lane i occupies [i*DATA_W +: DATA_W].
- tx_valid  out  1  tx_data holds a new word.
- rx_data  in  NUM_LANES*DATA_W  received words.
- rx_valid  in  NUM_LANES  per-lane word strobe.
- chk_clr  in  1  clear all error counters.
- lane_locked  out  NUM_LANES  per-lane checker lock.
- err_cnt  out  NUM_LANES*ERR_CNT_W  per-lane bit-error counts, saturating.

## Operation
- Bit ordering: bit 0 of each word is first in time, and each LFSR advances DATA_W steps per word.
- Generator: one shared LFSR, seeded to all-ones on reset and on any change of mode. Every lane transmits the same word.
- Generator output: each cycle with gen_en=1, tx_data is loaded with the next word and tx_valid is set to 1. With gen_en=0, tx_valid=0 and tx_data holds its value.
- Checker: each lane has its own state machine with states UNLOCKED, LOCKING and LOCKED. A lane acts only on cycles where its rx_valid bit is 1.
- UNLOCKED: the received word seeds the lane's LFSR, and the state moves to LOCKING with match count 0. An all-zero received word is not loaded, and the state stays UNLOCKED.
- LOCKING: the received word is compared with the predicted word.
  - Match: the match count increments. When it reaches LOCK_CNT, the state moves to LOCKED.
  - Mismatch: the state returns to UNLOCKED.
- LOCKED: the prediction always comes from the internal LFSR; received data is never re-seeded into it.
  - Mismatch: err_cnt increases by popcount(rx XOR prediction), and the consecutive-miss count increments.
  - Match: the consecutive-miss count is cleared.
  - When the miss count reaches LOCK_LOSS... specifically LOSS_CNT: the state moves to UNLOCKED. err_cnt is retained.
- Errors are counted only in LOCKED.
- err_cnt saturates at all-ones and never wraps.
- chk_clr zeroes every err_cnt. If chk_clr coincides with an error add, the clear wins and the counter reads 0.
- A change of mode forces every lane to UNLOCKED and reseeds the generator. err_cnt is not cleared.
- Reset values: tx_data 0, tx_valid 0, lane_locked 0, err_cnt 0, all lanes UNLOCKED, generator LFSR all-ones.

## Timing
- Generator latency: tx_valid and tx_data update on the clock edge after a cycle with gen_en=1.
- Compare and state update happen in the cycle a word is sampled. lane_locked rises on the edge after the LOCK_CNT-th consecutive match is sampled; after the seed word, that is LOCK_CNT+1 valid words in total.
- lane_locked falls on the edge after the LOSS_CNT-th consecutive mismatch.
- err_cnt pipeline: the popcount is registered, and the addition lands 2 edges after the erroneous word is sampled.
- chk_clr: takes effect on the next edge. A pipelined popcount still in flight at that edge is discarded.
- rst: mid-operation, rst restores all reset values on the next edge and has priority over every other input.

## Configuration
- PRBS_ERR_INJECT_EN defined: a 1 on inj_err inverts bit 0 of the next generated word on all lanes, one word per request.
  - A request made while gen_en=0 is held pending until the next generated word.
  - Further requests while one is pending are merged into it.
  - The LFSR state itself is never corrupted.
- PRBS_ERR_INJECT_EN undefined: the inj_err port remains but is ignored, and no injection logic is built.

## Test plan
- Reset, then NUM_LANES=4, mode=3, gen_en=1, tx looped to rx on all lanes -> all lane_locked=1 after 17 valid words (LOCK_CNT=16); err_cnt stays 0 for 10000 words.
- Locked loopback on lane 2 with 3 bits flipped in one word -> lane 2 err_cnt=3 exactly 2 edges later; other lanes stay 0; lane 2 stays locked.
- With the macro defined, 5 inj_err pulses spaced 100 cycles apart -> every lane err_cnt=5. With the macro undefined, the same stimulus -> err_cnt=0.
- Locked lane fed 8 consecutive random words (LOSS_CNT=8) -> lane_locked falls on the edge after the 8th; it relocks after a further 17 valid words of correct data.
- ERR_CNT_W=4, 20 single-bit errors -> err_cnt saturates at 15. chk_clr issued in the same cycle as an error add -> err_cnt reads 0.
- mode switched 3 to 0 while locked -> every lane_locked=0 on the next edge; relock in PRBS7 after 17 words. rst asserted mid-lock -> all outputs at reset values on the next edge.
